// File: rtl/vga_pkg.sv
// Shared constants for the VGA timing path: 640x480@60 segment defaults,
// derived frame totals, the raster counter width and a range-decode helper.
package vga_pkg;

  localparam int CNT_W = 10;

  localparam int DEF_H_VIS  = 640;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP   = 48;

  localparam int DEF_V_VIS  = 480;
  localparam int DEF_V_FP   = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 33;

  localparam int H_TOTAL = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // True when pos lies in the half-open window [lo, hi).
  function automatic logic in_span(input logic [CNT_W-1:0] pos,
                                   input logic [CNT_W-1:0] lo,
                                   input logic [CNT_W-1:0] hi);
    return (pos >= lo) && (pos < hi);
  endfunction

endpackage

// File: rtl/pixel_tick.sv
// Pixel-rate prescaler: emits a one-clock enable every DIV system clocks so
// downstream logic stays on the single system clock.
module pixel_tick #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic pix_en
);

  localparam int PS_W = $clog2(DIV);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(DIV - 1);
  localparam logic [PS_W-1:0] PS_ZERO = {PS_W{1'b0}};
  localparam logic [PS_W-1:0] PS_ONE  = PS_W'(1);

  if (DIV < 2 || DIV > 16) begin : g_div_range
    $error("pixel_tick: DIV must be within 2..16");
  end

  logic [PS_W-1:0] ps_r;

  // Free-running 0..DIV-1 count.
  always_ff @(posedge clk) begin
    if (rst) begin
      ps_r <= PS_ZERO;
    end else if (ps_r == PS_LAST) begin
      ps_r <= PS_ZERO;
    end else begin
      ps_r <= ps_r + PS_ONE;
    end
  end

  assign pix_en = (ps_r == PS_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: h/v counters advanced on the pixel strobe, with
// syncs, visible flag and line/frame strobes registered alongside the counters.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int DIV    = 4,
  parameter int H_VIS  = DEF_H_VIS,
  parameter int H_FP   = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP   = DEF_H_BP,
  parameter int V_VIS  = DEF_V_VIS,
  parameter int V_FP   = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP   = DEF_V_BP
) (
  input  logic             clk,
  input  logic             rst,
  output logic             pix_en,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             hsync,
  output logic             vsync,
  output logic             valid,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  if (H_TOT > (1 << CNT_W) || V_TOT > (1 << CNT_W)) begin : g_cnt_range
    $error("vga_timing_gen: frame totals do not fit the counter width");
  end

  localparam logic [CNT_W-1:0] ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] H_VEND = CNT_W'(H_VIS);
  localparam logic [CNT_W-1:0] V_VEND = CNT_W'(V_VIS);
  localparam logic [CNT_W-1:0] HS_LO  = CNT_W'(H_VIS + H_FP);
  localparam logic [CNT_W-1:0] HS_HI  = CNT_W'(H_VIS + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_LO  = CNT_W'(V_VIS + V_FP);
  localparam logic [CNT_W-1:0] VS_HI  = CNT_W'(V_VIS + V_FP + V_SYNC);

  logic [CNT_W-1:0] h_nxt_s;
  logic [CNT_W-1:0] v_nxt_s;

  pixel_tick #(.DIV(DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .pix_en (pix_en)
  );

  // Next raster position; decode below uses it so outputs align with counters.
  always_comb begin
    h_nxt_s = h_cnt;
    v_nxt_s = v_cnt;
    if (pix_en) begin
      if (h_cnt == H_LAST) begin
        h_nxt_s = ZERO;
        if (v_cnt == V_LAST) begin
          v_nxt_s = ZERO;
        end else begin
          v_nxt_s = v_cnt + ONE;
        end
      end else begin
        h_nxt_s = h_cnt + ONE;
        v_nxt_s = v_cnt;
      end
    end else begin
      h_nxt_s = h_cnt;
      v_nxt_s = v_cnt;
    end
  end

  // Counters and registered decode; reset parks at the last back-porch pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt       <= H_LAST;
      v_cnt       <= V_LAST;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      valid       <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (pix_en) begin
      h_cnt       <= h_nxt_s;
      v_cnt       <= v_nxt_s;
      hsync       <= ~in_span(h_nxt_s, HS_LO, HS_HI);
      vsync       <= ~in_span(v_nxt_s, VS_LO, VS_HI);
      valid       <= (h_nxt_s < H_VEND) && (v_nxt_s < V_VEND);
      line_start  <= (h_nxt_s == ZERO);
      frame_start <= (h_nxt_s == ZERO) && (v_nxt_s == ZERO);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size timing at DIV=4 for horizontal behaviour, plus a
// shrunken raster at DIV=2 so whole frames fit in a short run.
module tb_vga_timing_gen;

  logic       clk = 1'b0;
  logic       rst0, rst1;
  logic       pix0, hs0, vs0, vd0, ls0, fs0;
  logic [9:0] h0, v0;
  logic       pix1, hs1, vs1, vd1, ls1, fs1;
  logic [9:0] h1, v1;

  int passed = 0;
  int total  = 0;
  int ge     = 0;
  int ls_bad = 0;

  always #5 clk = ~clk;

  vga_timing_gen dut0 (
    .clk(clk), .rst(rst0), .pix_en(pix0), .h_cnt(h0), .v_cnt(v0),
    .hsync(hs0), .vsync(vs0), .valid(vd0), .line_start(ls0), .frame_start(fs0)
  );

  vga_timing_gen #(
    .DIV(2), .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VIS(6), .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) dut1 (
    .clk(clk), .rst(rst1), .pix_en(pix1), .h_cnt(h1), .v_cnt(v1),
    .hsync(hs1), .vsync(vs1), .valid(vd1), .line_start(ls1), .frame_start(fs1)
  );

  always @(negedge clk) begin
    if (!rst0 && ls0 && h0 != 10'd0) ls_bad++;
    if (!rst1 && ls1 && h1 != 10'd0) ls_bad++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      ge++;
    end
  endtask

  task automatic run_to(input int target);
    if (target > ge) step(target - ge);
  endtask

  typedef struct {
    int   k;
    int   h;
    int   v;
    logic hs;
    logic vs;
    logic vd;
    logic ls;
    logic fs;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int   rel0, rel1, e;
    int   vs_low, vd_pix, pix_bad;
    int   fs_t0, fs_t1, hs_t0, hs_t1;
    logic fs_prev, hs_prev;

    // k = pixel strobes since reset release; state sampled after edge 4k.
    tbl[0] = '{1,   0,   0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[1] = '{2,   1,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{640, 639, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{641, 640, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{656, 655, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{657, 656, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{752, 751, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{753, 752, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{800, 799, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    rst0 = 1'b1;
    rst1 = 1'b1;
    step(3);
    rst0 = 1'b0;
    rel0 = ge;

    chk("rst h_cnt", int'(h0), 799);
    chk("rst v_cnt", int'(v0), 524);
    chk("rst hsync", int'(hs0), 1);
    chk("rst vsync", int'(vs0), 1);
    chk("rst valid", int'(vd0), 0);
    chk("rst line_start", int'(ls0), 0);
    chk("rst frame_start", int'(fs0), 0);
    chk("rst pix_en", int'(pix0), 0);

    run_to(rel0 + 1); chk("pix_en edge1", int'(pix0), 0);
    run_to(rel0 + 2); chk("pix_en edge2", int'(pix0), 0);
    run_to(rel0 + 3); chk("pix_en edge3", int'(pix0), 1);
    chk("h_cnt before first pixel", int'(h0), 799);

    foreach (tbl[i]) begin
      run_to(rel0 + 4 * tbl[i].k);
      chk($sformatf("k%0d h_cnt", tbl[i].k), int'(h0), tbl[i].h);
      chk($sformatf("k%0d v_cnt", tbl[i].k), int'(v0), tbl[i].v);
      chk($sformatf("k%0d hsync", tbl[i].k), int'(hs0), int'(tbl[i].hs));
      chk($sformatf("k%0d vsync", tbl[i].k), int'(vs0), int'(tbl[i].vs));
      chk($sformatf("k%0d valid", tbl[i].k), int'(vd0), int'(tbl[i].vd));
      chk($sformatf("k%0d line_start", tbl[i].k), int'(ls0), int'(tbl[i].ls));
      chk($sformatf("k%0d frame_start", tbl[i].k), int'(fs0), int'(tbl[i].fs));
      run_to(rel0 + 4 * tbl[i].k + 2);
      chk($sformatf("k%0d h_cnt hold", tbl[i].k), int'(h0), tbl[i].h);
    end

    // Wrap 799 -> 0 into line 1: line_start high for exactly 4 clocks.
    for (int t = 3201; t <= 3212; t++) begin
      run_to(rel0 + t);
      chk($sformatf("wrap e%0d line_start", t), int'(ls0),
          (t >= 3204 && t <= 3207) ? 1 : 0);
      if (t == 3204) begin
        chk("wrap h_cnt", int'(h0), 0);
        chk("wrap v_cnt", int'(v0), 1);
        chk("wrap frame_start", int'(fs0), 0);
        chk("wrap valid", int'(vd0), 1);
      end
    end

    // One-cycle reset mid-line while hsync is low.
    run_to(rel0 + 4 * 1501);
    chk("pre-rst h_cnt", int'(h0), 700);
    chk("pre-rst v_cnt", int'(v0), 1);
    chk("pre-rst hsync", int'(hs0), 0);
    step(1);
    rst0 = 1'b1;
    step(1);
    rst0 = 1'b0;
    chk("mid-rst h_cnt", int'(h0), 799);
    chk("mid-rst v_cnt", int'(v0), 524);
    chk("mid-rst hsync", int'(hs0), 1);
    chk("mid-rst vsync", int'(vs0), 1);
    chk("mid-rst valid", int'(vd0), 0);
    chk("mid-rst pix_en", int'(pix0), 0);
    step(2);
    chk("mid-rst pix_en edge2", int'(pix0), 0);
    step(1);
    chk("mid-rst pix_en edge3", int'(pix0), 1);

    // Small raster, DIV=2: 16x12 totals, frame = 384 clocks.
    rst0 = 1'b1;
    rst1 = 1'b0;
    rel1 = ge;
    vs_low = 0; vd_pix = 0; pix_bad = 0;
    fs_t0 = -1; fs_t1 = -1; hs_t0 = -1; hs_t1 = -1;
    fs_prev = fs1; hs_prev = hs1;
    for (int i = 1; i <= 800; i++) begin
      step(1);
      e = i;
      if (int'(pix1) != (e % 2)) pix_bad++;
      if (e >= 2 && e <= 385) begin
        if (!vs1) vs_low++;
        if (vd1 && pix1) vd_pix++;
      end
      if (fs1 && !fs_prev) begin
        if (fs_t0 < 0) fs_t0 = e;
        else if (fs_t1 < 0) fs_t1 = e;
      end
      if (!hs1 && hs_prev) begin
        if (hs_t0 < 0) hs_t0 = e;
        else if (hs_t1 < 0) hs_t1 = e;
      end
      fs_prev = fs1;
      hs_prev = hs1;
    end
    chk("div2 pix_en alternation errors", pix_bad, 0);
    chk("div2 first frame_start edge", fs_t0, 2);
    chk("div2 frame_start period", fs_t1 - fs_t0, 384);
    chk("div2 first hsync fall edge", hs_t0, 22);
    chk("div2 hsync period", hs_t1 - hs_t0, 32);
    chk("div2 vsync low clocks", vs_low, 64);
    chk("div2 valid pixel periods", vd_pix, 48);

    // Reset while both syncs are low (h=11, v=9 in the third frame).
    run_to(rel1 + 1080);
    chk("s pre-rst h_cnt", int'(h1), 11);
    chk("s pre-rst v_cnt", int'(v1), 9);
    chk("s pre-rst hsync", int'(hs1), 0);
    chk("s pre-rst vsync", int'(vs1), 0);
    step(1);
    rst1 = 1'b1;
    step(1);
    rst1 = 1'b0;
    chk("s rst h_cnt", int'(h1), 15);
    chk("s rst v_cnt", int'(v1), 11);
    chk("s rst hsync", int'(hs1), 1);
    chk("s rst vsync", int'(vs1), 1);
    chk("s rst valid", int'(vd1), 0);
    chk("s rst pix_en", int'(pix1), 0);
    step(1);
    chk("s rst pix_en edge1", int'(pix1), 1);

    chk("line_start while h_cnt!=0", ls_bad, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
